// File: rtl/ccip_c0_rd_arb_if.sv
// Bundle of the request-side, host-side and response-side signals of the
// CCI-P channel 0 read arbiter.
//   slave  : the arbiter itself (takes port requests and host Rx, drives host Tx
//            and per-port responses/back-pressure)
//   master : the surrounding logic (AFU sub-engines plus host shim)
// Signals:
//   port_req_valid/port_req_hdr  per-port c0 requests (port i at [74*i +: 74])
//   port_almfull                 per-port back-pressure
//   port_rsp_valid/hdr/data      routed read responses (data broadcast)
//   c0TxAlmFull, c0_tx_valid/hdr host c0 Tx
//   c0_rx_rspValid/hdr/data      host c0 Rx
//   overflow_err, rsp_tag_err    sticky error flags
interface ccip_c0_rd_arb_if #(
  parameter int N_PORTS = 4
);
  logic [N_PORTS-1:0]    port_req_valid;
  logic [N_PORTS*74-1:0] port_req_hdr;
  logic [N_PORTS-1:0]    port_almfull;
  logic [N_PORTS-1:0]    port_rsp_valid;
  logic [27:0]           port_rsp_hdr;
  logic [511:0]          port_rsp_data;
  logic                  c0TxAlmFull;
  logic                  c0_tx_valid;
  logic [73:0]           c0_tx_hdr;
  logic                  c0_rx_rspValid;
  logic [27:0]           c0_rx_hdr;
  logic [511:0]          c0_rx_data;
  logic [N_PORTS-1:0]    overflow_err;
  logic                  rsp_tag_err;

  modport slave (
    input  port_req_valid, port_req_hdr, c0TxAlmFull,
           c0_rx_rspValid, c0_rx_hdr, c0_rx_data,
    output port_almfull, port_rsp_valid, port_rsp_hdr, port_rsp_data,
           c0_tx_valid, c0_tx_hdr, overflow_err, rsp_tag_err
  );

  modport master (
    output port_req_valid, port_req_hdr, c0TxAlmFull,
           c0_rx_rspValid, c0_rx_hdr, c0_rx_data,
    input  port_almfull, port_rsp_valid, port_rsp_hdr, port_rsp_data,
           c0_tx_valid, c0_tx_hdr, overflow_err, rsp_tag_err
  );
endinterface

// File: rtl/ccip_c0_rd_arb.sv
// N-port CCI-P channel 0 read-request arbiter and response router.
// Each port owns a request FIFO; a round-robin arbiter issues at most one
// request per cycle to the host while c0TxAlmFull is low, stamping the port
// index into mdata[15 -: IDX_W]. Read responses are routed back one cycle
// later by decoding that tag, which is cleared before delivery.
// Ports:
//   pClk                 clock
//   pck_cp2af_softReset  synchronous reset, active high
//   bus                  ccip_c0_rd_arb_if slave modport (requests, host Tx/Rx,
//                        responses, back-pressure, sticky errors)
module ccip_c0_rd_arb #(
  parameter int N_PORTS       = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int ALMFULL_SLACK = 8
) (
  input logic             pClk,
  input logic             pck_cp2af_softReset,
  ccip_c0_rd_arb_if.slave bus
);
  localparam int IDX_W = $clog2(N_PORTS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int HDR_W = 74;
  localparam logic [AW:0]      DEPTH_V    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      ALMFULL_TH = (AW+1)'(FIFO_DEPTH - ALMFULL_SLACK);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_PORTS - 1);

  logic [HDR_W-1:0]   mem     [N_PORTS][FIFO_DEPTH];
  logic [AW:0]        wr_ptr  [N_PORTS];
  logic [AW:0]        rd_ptr  [N_PORTS];
  logic [AW:0]        occ     [N_PORTS];
  logic [AW:0]        occ_nxt [N_PORTS];
  logic [N_PORTS-1:0] full, elig, wr_ok, pop;
  logic [IDX_W-1:0]   ptr, win, cand;
  logic               grant;
  logic [HDR_W-1:0]   tx_hdr_nxt;

  logic [N_PORTS-1:0] almfull_q, ovf_q, rsp_valid_q;
  logic               tx_valid_q, tag_err_q;
  logic [HDR_W-1:0]   tx_hdr_q;
  logic [27:0]        rsp_hdr_q, rx_hdr_clr;
  logic [511:0]       rsp_data_q;
  logic [31:0]        rx_tag;

  // Full is judged on pre-edge occupancy, so a write to a full FIFO is dropped
  // even when the same FIFO is popped in this cycle.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      occ[i]   = wr_ptr[i] - rd_ptr[i];
      full[i]  = (occ[i] == DEPTH_V);
      elig[i]  = (occ[i] != '0) && !bus.c0TxAlmFull;
      wr_ok[i] = bus.port_req_valid[i] && !full[i];
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    cand  = ptr;
    for (int off = 0; off < N_PORTS; off++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!grant && elig[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      pop[i]     = grant && (win == IDX_W'(i));
      occ_nxt[i] = occ[i] + (AW+1)'(wr_ok[i]) - (AW+1)'(pop[i]);
    end
    tx_hdr_nxt              = mem[win][rd_ptr[win][AW-1:0]];
    tx_hdr_nxt[15 -: IDX_W] = win;
  end

  always_ff @(posedge pClk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (wr_ok[i]) mem[i][wr_ptr[i][AW-1:0]] <= bus.port_req_hdr[HDR_W*i +: HDR_W];
    end
  end

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      for (int i = 0; i < N_PORTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      ptr        <= LAST_IDX;
      almfull_q  <= '0;
      ovf_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_hdr_q   <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (wr_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (bus.port_req_valid[i] && full[i]) ovf_q[i] <= 1'b1;
        almfull_q[i] <= (occ_nxt[i] >= ALMFULL_TH);
      end
      tx_valid_q <= grant;
      if (grant) begin
        ptr      <= win;
        tx_hdr_q <= tx_hdr_nxt;
      end
    end
  end

  always_comb begin
    rx_tag                  = 32'(bus.c0_rx_hdr[15 -: IDX_W]);
    rx_hdr_clr              = bus.c0_rx_hdr;
    rx_hdr_clr[15 -: IDX_W] = '0;
  end

  // Tags that name no port can only occur when N_PORTS is not a power of 2.
  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      rsp_valid_q <= '0;
      rsp_hdr_q   <= '0;
      rsp_data_q  <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (bus.c0_rx_rspValid) begin
        if (rx_tag < 32'(N_PORTS)) begin
          rsp_valid_q <= N_PORTS'(1) << rx_tag;
          rsp_hdr_q   <= rx_hdr_clr;
          rsp_data_q  <= bus.c0_rx_data;
        end else begin
          tag_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.port_almfull   = almfull_q;
  assign bus.overflow_err   = ovf_q;
  assign bus.c0_tx_valid    = tx_valid_q;
  assign bus.c0_tx_hdr      = tx_hdr_q;
  assign bus.port_rsp_valid = rsp_valid_q;
  assign bus.port_rsp_hdr   = rsp_hdr_q;
  assign bus.port_rsp_data  = rsp_data_q;
  assign bus.rsp_tag_err    = tag_err_q;
endmodule
